// File: rtl/rf_wb_queue.sv
// ---------------------------------------------------------------------------
// rf_wb_queue
// Merges two register-file write sources onto the single register-file write
// port. The sources are the datapath writeback and the link (return-address)
// write, which always targets r31. Writes leave one per cycle, in the order
// they were accepted. A small FIFO absorbs bursts. A combinational lookup port
// lets hazard logic find the newest pending value for a register.
//
// Ports:
//   clk, rst_n            single clock, asynchronous active-low reset
//   wb_valid/addr/data    datapath writeback request (addr 0 is dropped)
//   link_valid/link_data  link write request, implicitly to r31
//   stall                 requests are ignored this cycle; the datapath holds
//   rf_we/waddr/wdata     registered register-file write port
//   q_addr                hazard lookup address
//   q_hit/q_data          a pending write to q_addr exists / its newest data
// ---------------------------------------------------------------------------
module rf_wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_valid,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        link_valid,
    input  logic [31:0] link_data,
    output logic        stall,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    input  logic [4:0]  q_addr,
    output logic        q_hit,
    output logic [31:0] q_data
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] wr_ptr_p1;
    logic [PW-1:0] lk_idx;
    logic [4:0]    mem_addr [DEPTH];
    logic [31:0]   mem_data [DEPTH];

    logic          wb_acc;
    logic          link_acc;
    logic          first_v;
    logic [4:0]    first_addr;
    logic [31:0]   first_data;
    logic          second_v;
    logic          pop;
    logic          push0_v;
    logic [4:0]    push0_addr;
    logic [31:0]   push0_data;
    logic          push1_v;
    logic [CW-1:0] count_next;

    // Stall leaves room for two pushes at the next edge. The output register
    // pops one entry per cycle, so the FIFO can never overflow.
    assign stall = (count > CW'(DEPTH - 2));

    // Order the accepted requests of this edge (wb before link). If the FIFO
    // holds anything, its head goes to the output register, and every new
    // request is pushed behind it. Otherwise the first new request bypasses
    // the FIFO, and only the second one, if any, is pushed.
    always_comb begin
        wb_acc     = wb_valid && !stall && (wb_addr != 5'd0);
        link_acc   = link_valid && !stall;
        first_v    = wb_acc || link_acc;
        first_addr = wb_acc ? wb_addr : 5'd31;
        first_data = wb_acc ? wb_data : link_data;
        second_v   = wb_acc && link_acc;
        pop        = (count != '0);
        push0_v    = pop ? first_v : second_v;
        push0_addr = pop ? first_addr : 5'd31;
        push0_data = pop ? first_data : link_data;
        push1_v    = pop && second_v;
        wr_ptr_p1  = wr_ptr + PW'(1);
        count_next = count + CW'(push0_v) + CW'(push1_v) - CW'(pop);
    end

    // Pointers, occupancy and the registered write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= 32'd0;
        end else begin
            count  <= count_next;
            wr_ptr <= wr_ptr + PW'(push0_v) + PW'(push1_v);
            if (pop) begin
                rd_ptr   <= rd_ptr + PW'(1);
                rf_we    <= 1'b1;
                rf_waddr <= mem_addr[rd_ptr];
                rf_wdata <= mem_data[rd_ptr];
            end else if (first_v) begin
                rf_we    <= 1'b1;
                rf_waddr <= first_addr;
                rf_wdata <= first_data;
            end else begin
                rf_we    <= 1'b0;
            end
        end
    end

    // FIFO storage. It needs no reset because count alone decides which
    // entries are valid. The second push is always the link write.
    always_ff @(posedge clk) begin
        if (push0_v) begin
            mem_addr[wr_ptr] <= push0_addr;
            mem_data[wr_ptr] <= push0_data;
        end
        if (push1_v) begin
            mem_addr[wr_ptr_p1] <= 5'd31;
            mem_data[wr_ptr_p1] <= link_data;
        end
    end

    // Hazard lookup. The output register is checked first. The FIFO is then
    // scanned from oldest to newest, so a newer match overwrites an older one.
    always_comb begin
        q_hit  = 1'b0;
        q_data = 32'd0;
        lk_idx = rd_ptr;
        if (q_addr != 5'd0) begin
            if (rf_we && (rf_waddr == q_addr)) begin
                q_hit  = 1'b1;
                q_data = rf_wdata;
            end
            for (int i = 0; i < DEPTH; i++) begin
                lk_idx = rd_ptr + PW'(i);
                if ((CW'(i) < count) && (mem_addr[lk_idx] == q_addr)) begin
                    q_hit  = 1'b1;
                    q_data = mem_data[lk_idx];
                end
            end
        end
    end

endmodule

// File: doc/rf_wb_queue.md
RF_WB_QUEUE -- requirements
Module: rf_wb_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of FIFO entries (power of two, >=2).
REQ-002 Clock and reset: clk is the single clock (rising edge); reset is asynchronous and active-low, named rst_n.
REQ-003 clk  in  1  system clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 wb_valid  in  1  datapath writeback request.
REQ-006 wb_addr  in  5  writeback destination register.
REQ-007 wb_data  in  32  writeback data.
REQ-008 link_valid  in  1  link (return-address) write request to r31.
REQ-009 link_data  in  32  link data (PC+8).
REQ-010 stall  out  1  requests not accepted this cycle; datapath shall hold.
REQ-011 rf_we  out  1  register-file write enable (registered).
REQ-012 rf_waddr  out  5  register-file write address (registered).
REQ-013 rf_wdata  out  32  register-file write data (registered).
REQ-014 q_addr  in  5  hazard lookup address.
REQ-015 q_hit  out  1  a pending write to q_addr exists.
REQ-016 q_data  out  32  data of the newest pending write to q_addr.

Function
REQ-017 The block SHALL serialize the two write sources onto the single register-file write port, one write per cycle, in acceptance order.
REQ-018 A request SHALL be accepted at a rising edge only if stall=0 at that edge; when stall=1, requests SHALL be ignored, with no state change.
REQ-019 A wb request with wb_addr=0 SHALL be accepted and discarded (no FIFO entry, no rf_we).
REQ-020 When wb and link are accepted at the same edge, wb SHALL be ordered before link.
REQ-021 Per edge, the output register SHALL load, in priority: the FIFO head if count>0; else the first accepted request of that edge; else nothing (rf_we=0).
REQ-022 Accepted requests not loaded into the output register SHALL be pushed to the FIFO tail in order; push and pop at the same edge are legal.
REQ-023 Latency: with an empty FIFO, a request accepted at edge k SHALL have rf_we=1 in the cycle following edge k.
REQ-024 count (FIFO occupancy, excluding the output register) SHALL range 0..DEPTH; pointers SHALL wrap modulo DEPTH.
REQ-025 stall SHALL equal (count > DEPTH-2), combinationally from count only, so that two pushes never overflow.
REQ-026 rf_we SHALL be 1 for exactly one cycle per surviving request; rf_waddr/rf_wdata SHALL hold their last values when rf_we=0.
REQ-027 q_hit SHALL be 1 when q_addr!=0 and any valid FIFO entry or the output register with rf_we=1 targets q_addr; otherwise 0.
REQ-028 q_data SHALL come from the newest match (tail-most FIFO entry first, then the output register), and SHALL be 0 when q_hit=0.
REQ-029 Link requests SHALL always target address 31.

Reset
REQ-030 On rst_n=0, asynchronously: count=0, pointers=0, rf_we=0, rf_waddr=0, rf_wdata=0; stall and q_hit SHALL then read 0.
REQ-031 Reset asserted mid-operation SHALL discard all pending FIFO entries without issuing any rf_we.
REQ-032 Requests SHALL be accepted only at the first rising edge after rst_n deasserts.

Verification
REQ-033 Single write: empty queue, wb (addr 5, data 0x1234) for 1 cycle -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234; following cycle rf_we=0.
REQ-034 Simultaneous: wb (addr 3, 0xA) and link (0x400008) at the same edge -> rf_we on two consecutive cycles: (3,0xA) then (31,0x400008); count peaks at 1.
REQ-035 Full/stall: DEPTH=4, wb+link on every cycle -> stall rises when count=3; no write is lost or duplicated; drain order matches issue order.
REQ-036 r0 drop: wb addr 0, data 0xFFFF -> no rf_we; q_addr=0 -> q_hit=0.
REQ-037 Hazard lookup: pending entries (7,0x11) then (7,0x22), q_addr=7 -> q_hit=1, q_data=0x22; after both drain -> q_hit=0, q_data=0.
REQ-038 Reset mid-operation: 3 entries queued, rst_n pulsed low -> rf_we=0 immediately, count=0, no writes after release.
